imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage of the pipelined RISC-V core.
- Decodes all base formats (R/I/S/B/U/J) and sign-extends the immediate to XLEN.
- Flags illegal or compressed encodings and carries the PC alongside each result.
- Sits between fetch and the register-read stage behind a valid/ready handshake, with a 2-entry skid buffer so throughput is full even under backpressure.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
PC_W, XLEN, width of the carried PC.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset; asynchronous assert, active-low
flush  in  1  synchronous pipeline kill
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept this cycle
in_instr  in  32  raw instruction word
in_pc  in  PC_W  instruction address
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  format code (see package)
out_pc  out  PC_W  PC of the result
out_illegal  out  1  unrecognised or compressed encoding
out_target  out  PC_W  out_pc + out_imm (see Optional Feature)

Behaviour:
Reset (rst_n low, asynchronous):
- Both buffer entries invalid.
- out_valid=0, in_ready=1 (as soon as rst_n deasserts).
- out_imm, out_pc, out_target, out_fmt and out_illegal all 0.
- Reset mid-transfer drops all in-flight entries.

Decode (combinational, sub-module):
- I-type: opcodes 0010011, 0000011, 1100111, 0001111, 1110011, plus 0011011 when XLEN=64.
  - imm = sext(instr[31:20]).
  - Shifts (opcode 0010011/0011011, funct3 001/101): imm = zext(shamt); shamt is instr[24:20] for XLEN=32, instr[25:20] for XLEN=64.
- S-type: opcode 0100011; imm = sext({instr[31:25], instr[11:7]}).
- B-type: opcode 1100011; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- U-type: opcodes 0110111, 0010111; imm = sext({instr[31:12], 12'b0}). Upper bits replicate instr[31] when XLEN=64.
- J-type: opcode 1101111; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- R-type: opcodes 0110011, 0111011 (XLEN=64 only): imm=0, fmt=R.
- Anything else, or instr[1:0]!=2'b11: imm=0, fmt=NONE, out_illegal=1.

Handshake and pipeline:
- Transfer on valid&&ready at the clock edge.
- Latency: 1 cycle from input accept to out_valid.
- Output register plus one skid entry.
- in_ready = !skid_valid (registered; no combinational path from out_ready).
- When the output stalls (out_valid && !out_ready) and an input is accepted, the input goes to the skid entry. The skid entry promotes to the output on the next out_ready.
- Output fields hold stable while out_valid && !out_ready.
- Order is strictly preserved.
- Back-to-back transfers give 1 result per cycle.

flush:
- Invalidates both entries at the next edge.
- An input offered in the flush cycle is discarded even if in_ready=1.
- flush wins over simultaneous accept and promote.
- in_ready=1 the cycle after flush.

Optional Feature:
Macro IMM_TARGET_EN.
- Defined: out_target = out_pc + out_imm (truncated to PC_W), computed before the output register, for fmt B, J, and AUIPC (opcode 0010111). It is 0 for all other formats. Latency is unchanged.
- Undefined: no adder is built and out_target is tied 0.

Decomposition:
- Shared defines file:
  - FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_NONE=7.
  - Opcode constants (OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM32, OP_REG, OP_REG32, OP_FENCE, OP_SYSTEM).
- Sub-module imm_decode:
  - Purely combinational; maps instr to {imm, fmt, illegal}, parametrised by XLEN.
  - imm_gen_pipe owns the skid buffer, flush and optional adder.

Test Plan:
1. XLEN=32, in_instr=32'hFCE08713 (addi x14,x1,-50), out_ready=1 -> next cycle out_imm=32'hFFFFFFCE, out_fmt=I, out_illegal=0.
2. in_instr=32'hFCE08723 (store) -> out_imm=32'hFFFFFFCE, fmt=S; 32'hFCE08763 (branch) -> out_imm=32'hFFFFF7CE, fmt=B; 32'hFFDFF06F (jal -4) -> 32'hFFFFFFFC, fmt=J.
3. XLEN=64, in_instr=32'hABCDE0B7 (lui) -> out_imm=64'hFFFFFFFFABCDE000, fmt=U; slli with shamt 33 -> out_imm=33.
4. Backpressure: stream 4 instructions with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, out fields stable; release -> 4 results in order, no loss or duplication.
5. flush asserted with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed instruction never appears; in_instr=32'h00000000 -> out_illegal=1, fmt=NONE, imm=0.
6. IMM_TARGET_EN defined, in_pc=32'h00001000, branch 32'hFCE08763 -> out_target=32'h000007CE; same stimulus with the macro undefined -> out_target=0. Assert rst_n low mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_pkg
// Shared definitions for the decode-stage immediate generator:
//   - fmt_t      : 3-bit format code reported on out_fmt
//   - OP_*       : RISC-V base opcode constants (instr[6:0])
//   - is_shift() : recognises the shift-immediate funct3 encodings
// ---------------------------------------------------------------------------
package imm_gen_pipe_pkg;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // SLLI/SRLI/SRAI (and their W forms) use funct3 001 and 101; their
   // immediate field carries a shift amount rather than a signed constant.
   function automatic logic is_shift(input logic [2:0] funct3);
      return (funct3 == 3'b001) || (funct3 == 3'b101);
   endfunction

endpackage

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
// Purely combinational immediate decoder for one 32-bit RISC-V instruction.
// Parameters:
//   XLEN    : datapath width, 32 or 64
// Ports:
//   instr   in  32    raw instruction word
//   imm     out XLEN  sign-extended (or zero-extended shamt) immediate
//   fmt     out 3     format code (fmt_t)
//   illegal out 1     unrecognised opcode or compressed encoding
// ---------------------------------------------------------------------------
module imm_decode
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output fmt_t            fmt,
   output logic            illegal
);

   localparam bit IS64 = (XLEN == 64);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [5:0]  shamt;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   // Every format is first assembled as a 32-bit sign-extended value; the
   // widening to XLEN below is then a single signed cast, so RV64 upper
   // bits always replicate instr[31].
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign shamt  = IS64 ? instr[25:20] : {1'b0, instr[24:20]};
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'b0};
   assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // Opcode dispatch. Defaults describe an illegal instruction so that any
   // unlisted opcode, an RV64-only opcode on RV32, or a compressed encoding
   // (instr[1:0] != 2'b11) falls out as imm=0, fmt=NONE, illegal=1.
   always_comb begin
      imm     = '0;
      fmt     = FMT_NONE;
      illegal = 1'b1;
      if (instr[1:0] == 2'b11) begin
         case (opcode)
            OP_IMM: begin
               fmt     = FMT_I;
               illegal = 1'b0;
               imm     = is_shift(funct3) ? XLEN'(shamt) : sext32(imm_i);
            end
            OP_IMM32: begin
               if (IS64) begin
                  fmt     = FMT_I;
                  illegal = 1'b0;
                  imm     = is_shift(funct3) ? XLEN'(shamt) : sext32(imm_i);
               end
            end
            OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
               fmt     = FMT_I;
               illegal = 1'b0;
               imm     = sext32(imm_i);
            end
            OP_STORE: begin
               fmt     = FMT_S;
               illegal = 1'b0;
               imm     = sext32(imm_s);
            end
            OP_BRANCH: begin
               fmt     = FMT_B;
               illegal = 1'b0;
               imm     = sext32(imm_b);
            end
            OP_LUI, OP_AUIPC: begin
               fmt     = FMT_U;
               illegal = 1'b0;
               imm     = sext32(imm_u);
            end
            OP_JAL: begin
               fmt     = FMT_J;
               illegal = 1'b0;
               imm     = sext32(imm_j);
            end
            OP_REG: begin
               fmt     = FMT_R;
               illegal = 1'b0;
            end
            OP_REG32: begin
               if (IS64) begin
                  fmt     = FMT_R;
                  illegal = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined immediate generator for the decode stage. One output register
// plus one skid entry behind a valid/ready handshake; 1-cycle latency and
// full throughput under backpressure.
// Parameters:
//   XLEN  : datapath width, 32 or 64
//   PC_W  : width of the carried PC (default XLEN)
// Optional build macro:
//   IMM_TARGET_EN : when defined, out_target = out_pc + out_imm for B, J and
//                   AUIPC results (0 otherwise); when undefined no adder is
//                   built and out_target is tied 0.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         synchronous kill of both entries (and the offered input)
//   in_valid/in_ready/in_instr/in_pc          upstream handshake + payload
//   out_valid/out_ready                       downstream handshake
//   out_imm/out_fmt/out_pc/out_illegal/out_target  result payload
// ---------------------------------------------------------------------------
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [PC_W-1:0] out_pc,
   output logic            out_illegal,
   output logic [PC_W-1:0] out_target
);

   logic [XLEN-1:0] dec_imm;
   fmt_t            dec_fmt;
   logic            dec_illegal;
   logic [PC_W-1:0] dec_target;

   logic            skid_valid;
   logic [XLEN-1:0] skid_imm;
   logic [2:0]      skid_fmt;
   logic [PC_W-1:0] skid_pc;
   logic            skid_illegal;
   logic [PC_W-1:0] skid_target;

   logic accept;
   logic out_free;
   logic out_load;
   logic skid_load;

   imm_decode #(
      .XLEN(XLEN)
   ) u_decode (
      .instr  (in_instr),
      .imm    (dec_imm),
      .fmt    (dec_fmt),
      .illegal(dec_illegal)
   );

`ifdef IMM_TARGET_EN
   // Branch/jump/AUIPC target, formed before the output register so the
   // result appears with the same latency as the immediate itself.
   always_comb begin
      dec_target = '0;
      if (!dec_illegal &&
          (dec_fmt == FMT_B || dec_fmt == FMT_J || in_instr[6:0] == OP_AUIPC)) begin
         dec_target = in_pc + PC_W'($signed(dec_imm));
      end
   end
`else
   assign dec_target = '0;
`endif

   // in_ready depends only on registered state, so out_ready never reaches
   // in_ready combinationally. A flush cycle discards the offered input.
   assign in_ready  = !skid_valid;
   assign accept    = in_valid && in_ready && !flush;
   assign out_free  = !out_valid || out_ready;
   assign out_load  = !flush && out_free && (skid_valid || accept);
   assign skid_load = accept && !out_free;

   // Occupancy of the two entries. The skid entry only fills when the output
   // is stalled; when the output frees, the skid entry (older) moves ahead of
   // any new input, which cannot be accepted in that cycle anyway.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (out_free) begin
         out_valid  <= skid_valid || accept;
         skid_valid <= 1'b0;
      end else if (accept) begin
         skid_valid <= 1'b1;
      end
   end

   // Output payload: loaded from the skid entry when it holds data, else from
   // the decoder; otherwise held so fields stay stable during a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_imm     <= '0;
         out_fmt     <= '0;
         out_pc      <= '0;
         out_illegal <= 1'b0;
         out_target  <= '0;
      end else if (out_load) begin
         if (skid_valid) begin
            out_imm     <= skid_imm;
            out_fmt     <= skid_fmt;
            out_pc      <= skid_pc;
            out_illegal <= skid_illegal;
            out_target  <= skid_target;
         end else begin
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_pc      <= in_pc;
            out_illegal <= dec_illegal;
            out_target  <= dec_target;
         end
      end
   end

   // Skid payload: captures the decoded input accepted while the output
   // register is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_imm     <= '0;
         skid_fmt     <= '0;
         skid_pc      <= '0;
         skid_illegal <= 1'b0;
         skid_target  <= '0;
      end else if (skid_load) begin
         skid_imm     <= dec_imm;
         skid_fmt     <= dec_fmt;
         skid_pc      <= in_pc;
         skid_illegal <= dec_illegal;
         skid_target  <= dec_target;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
// Directed bench for imm_gen_pipe: an XLEN=32 instance carries the decode,
// handshake, flush, target and reset scenarios; an XLEN=64 instance covers
// the RV64-specific decodes. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

   logic        clk;
   logic        rst_n;
   logic        flush;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [2:0]  out_fmt;
   logic [31:0] out_pc;
   logic        out_illegal;
   logic [31:0] out_target;

   logic        in_valid64;
   logic        in_ready64;
   logic [31:0] in_instr64;
   logic [63:0] in_pc64;
   logic        out_valid64;
   logic        out_ready64;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt64;
   logic [63:0] out_pc64;
   logic        out_illegal64;
   logic [63:0] out_target64;

   int n_vec;
   int n_err;

   imm_gen_pipe #(.XLEN(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_fmt(out_fmt), .out_pc(out_pc), .out_illegal(out_illegal),
      .out_target(out_target)
   );

   imm_gen_pipe #(.XLEN(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
      .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
      .out_fmt(out_fmt64), .out_pc(out_pc64), .out_illegal(out_illegal64),
      .out_target(out_target64)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset state of both instances
   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0;
      in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
      in_valid64 = 1'b0; in_instr64 = '0; in_pc64 = '0; out_ready64 = 1'b1;
      tick(); tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
      n_vec++; if (out_imm !== 32'h0) begin n_err++; $display("[TB] FAIL reset_out_imm got %h want 0", out_imm); end
      n_vec++; if (out_fmt !== 3'd0) begin n_err++; $display("[TB] FAIL reset_out_fmt got %0d want 0", out_fmt); end
      n_vec++; if (out_illegal !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_illegal got %b want 0", out_illegal); end
      n_vec++; if (out_pc !== 32'h0 || out_target !== 32'h0) begin n_err++; $display("[TB] FAIL reset_pc_target got %h/%h want 0/0", out_pc, out_target); end
      n_vec++; if (out_valid64 !== 1'b0 || out_imm64 !== 64'h0) begin n_err++; $display("[TB] FAIL reset64 got v=%b imm=%h want 0/0", out_valid64, out_imm64); end
      rst_n = 1'b1;
      tick();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL post_reset_in_ready got %b want 1", in_ready); end
   endtask

   // RV32 decode, streamed back to back with out_ready=1
   task automatic test_decode32();
      logic [31:0] instr_v [10];
      logic [31:0] imm_v   [10];
      logic [2:0]  fmt_v   [10];
      logic        ill_v   [10];
      instr_v = '{32'hFCE08713, 32'hFCE08723, 32'hFCE08763, 32'hFFDFF06F, 32'h00000000,
                  32'h00509093, 32'h4030D093, 32'h12345037, 32'h002081B3, 32'h0010081B};
      imm_v   = '{32'hFFFFFFCE, 32'hFFFFFFCE, 32'hFFFFF7CE, 32'hFFFFFFFC, 32'h0,
                  32'h5,        32'h3,        32'h12345000, 32'h0,        32'h0};
      fmt_v   = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd7, 3'd1, 3'd1, 3'd4, 3'd0, 3'd7};
      ill_v   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_instr = instr_v[i];
         in_pc    = 32'h100 + 32'(i * 4);
         tick();
         n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL dec32_valid[%0d] got %b want 1", i, out_valid); end
         n_vec++; if (out_imm !== imm_v[i]) begin n_err++; $display("[TB] FAIL dec32_imm[%0d] got %h want %h", i, out_imm, imm_v[i]); end
         n_vec++; if (out_fmt !== fmt_v[i]) begin n_err++; $display("[TB] FAIL dec32_fmt[%0d] got %0d want %0d", i, out_fmt, fmt_v[i]); end
         n_vec++; if (out_illegal !== ill_v[i]) begin n_err++; $display("[TB] FAIL dec32_illegal[%0d] got %b want %b", i, out_illegal, ill_v[i]); end
         n_vec++; if (out_pc !== 32'h100 + 32'(i * 4)) begin n_err++; $display("[TB] FAIL dec32_pc[%0d] got %h want %h", i, out_pc, 32'h100 + 32'(i * 4)); end
      end
      in_valid = 1'b0;
      in_instr = 32'h00000001;
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL dec32_drain got %b want 0", out_valid); end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_vec++; if (out_illegal !== 1'b1 || out_fmt !== 3'd7) begin n_err++; $display("[TB] FAIL dec32_compressed got ill=%b fmt=%0d want 1/7", out_illegal, out_fmt); end
      tick();
   endtask

   // RV64-only decodes on the 64-bit instance
   task automatic test_decode64();
      logic [31:0] instr_v [5];
      logic [63:0] imm_v   [5];
      logic [2:0]  fmt_v   [5];
      instr_v = '{32'hABCDE0B7, 32'h02109093, 32'hFFF0809B, 32'h0020803B, 32'hFFDFF06F};
      imm_v   = '{64'hFFFFFFFFABCDE000, 64'd33, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFC};
      fmt_v   = '{3'd4, 3'd1, 3'd1, 3'd0, 3'd5};
      out_ready64 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid64 = 1'b1;
         in_instr64 = instr_v[i];
         in_pc64    = 64'h8000_0000 + 64'(i * 4);
         tick();
         n_vec++; if (out_valid64 !== 1'b1 || out_illegal64 !== 1'b0) begin n_err++; $display("[TB] FAIL dec64_valid[%0d] got v=%b ill=%b want 1/0", i, out_valid64, out_illegal64); end
         n_vec++; if (out_imm64 !== imm_v[i]) begin n_err++; $display("[TB] FAIL dec64_imm[%0d] got %h want %h", i, out_imm64, imm_v[i]); end
         n_vec++; if (out_fmt64 !== fmt_v[i]) begin n_err++; $display("[TB] FAIL dec64_fmt[%0d] got %0d want %0d", i, out_fmt64, fmt_v[i]); end
      end
      in_valid64 = 1'b0;
      tick();
   endtask

   // Four instructions through a 3-cycle stall, then drained in order
   task automatic test_backpressure();
      logic [31:0] instr_v [4];
      logic [31:0] imm_v   [4];
      int idx;
      int nout;
      logic acc;
      logic cons;
      instr_v = '{32'h00108093, 32'h00208093, 32'h00308093, 32'h00408093};
      imm_v   = '{32'd1, 32'd2, 32'd3, 32'd4};
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = instr_v[0]; in_pc = 32'h400;
      tick();
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_first got rdy=%b v=%b want 1/1", in_ready, out_valid); end
      in_instr = instr_v[1]; in_pc = 32'h404;
      tick();
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_in_ready_drop got %b want 0", in_ready); end
      in_instr = instr_v[2]; in_pc = 32'h408;
      tick();
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_in_ready_held got %b want 0", in_ready); end
      n_vec++; if (out_imm !== 32'd1 || out_pc !== 32'h400) begin n_err++; $display("[TB] FAIL bp_stable got imm=%h pc=%h want 1/400", out_imm, out_pc); end
      out_ready = 1'b1;
      idx = 2;
      nout = 0;
      for (int c = 0; c < 12; c++) begin
         in_valid = (idx < 4);
         if (idx < 4) begin
            in_instr = instr_v[idx];
            in_pc    = 32'h400 + 32'(idx * 4);
         end
         acc  = in_valid && in_ready;
         cons = out_valid && out_ready;
         if (cons) begin
            n_vec++;
            if (nout >= 4) begin
               n_err++; $display("[TB] FAIL bp_extra_result got imm=%h want none", out_imm);
            end else if (out_imm !== imm_v[nout]) begin
               n_err++; $display("[TB] FAIL bp_order[%0d] got %h want %h", nout, out_imm, imm_v[nout]);
            end
            nout++;
         end
         tick();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      n_vec++; if (nout !== 4 || idx !== 4) begin n_err++; $display("[TB] FAIL bp_count got out=%0d in=%0d want 4/4", nout, idx); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_empty got %b want 0", out_valid); end
   endtask

   // flush with both entries full, flush with an empty pipe, then illegal word
   task automatic test_flush();
      logic seen;
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00508093; in_pc = 32'h500;
      tick();
      in_instr = 32'h00608093; in_pc = 32'h504;
      tick();
      in_instr = 32'h00708093; in_pc = 32'h508;
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flush_full got v=%b rdy=%b want 0/1", out_valid, in_ready); end
      out_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("[TB] FAIL flush_ghost got %b want 0", seen); end
      in_valid = 1'b1; in_instr = 32'h00808093; in_pc = 32'h50C;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_discard got %b want 0", out_valid); end
      in_instr = 32'h00000000; in_pc = 32'h510;
      tick();
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin n_err++; $display("[TB] FAIL zero_illegal got v=%b ill=%b want 1/1", out_valid, out_illegal); end
      n_vec++; if (out_fmt !== 3'd7 || out_imm !== 32'h0) begin n_err++; $display("[TB] FAIL zero_fmt_imm got fmt=%0d imm=%h want 7/0", out_fmt, out_imm); end
      tick();
   endtask

   // Branch/jump/AUIPC target (0 when the feature is not built)
   task automatic test_target();
      logic [31:0] instr_v [4];
      logic [31:0] pc_v    [4];
      logic [31:0] tgt_v   [4];
      instr_v = '{32'hFCE08763, 32'hFFDFF06F, 32'h00001097, 32'hFCE08713};
      pc_v    = '{32'h00001000, 32'h00002000, 32'h00000100, 32'h00003000};
`ifdef IMM_TARGET_EN
      tgt_v   = '{32'h000007CE, 32'h00001FFC, 32'h00001100, 32'h0};
`else
      tgt_v   = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_instr = instr_v[i]; in_pc = pc_v[i];
         tick();
         n_vec++; if (out_target !== tgt_v[i] || out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL target[%0d] got %h v=%b want %h", i, out_target, out_valid, tgt_v[i]); end
      end
      in_valid = 1'b0;
      tick();
   endtask

   // Asynchronous reset in the middle of a stalled stream
   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00908093; in_pc = 32'h600;
      tick();
      in_instr = 32'h00A08093; in_pc = 32'h604;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_mid got v=%b rdy=%b want 0/1", out_valid, in_ready); end
      n_vec++; if (out_imm !== 32'h0 || out_pc !== 32'h0) begin n_err++; $display("[TB] FAIL reset_mid_data got imm=%h pc=%h want 0/0", out_imm, out_pc); end
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick(); tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_mid_dropped got %b want 0", out_valid); end
   endtask

   // Scenario sequence and summary
   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_decode32();
      test_decode64();
      test_backpressure();
      test_flush();
      test_target();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
